// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Build option: UART_TX_BREAK_EN adds the BREAK and MAB states.
package uart_pkg;

    localparam int unsigned MIN_DATA_BITS    = 5;
    localparam int unsigned OVERSAMPLE_SHIFT = 3;
    localparam int unsigned DBITS_W          = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK,
        MAB
`endif
    } state_t;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_t;

    // Frame format captured at the handshake
    typedef struct packed {
        logic [DBITS_W-1:0] nbits;
        parity_t            pmode;
        logic               stop2;
    } frame_cfg_t;

    // Undefined parity encodings fall back to no parity
    function automatic parity_t norm_parity(input logic [2:0] m);
        if (m > 3'd4) return PAR_NONE;
        return parity_t'(m);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// AXI4-Stream word channel feeding the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_baud_timer.sv
// Loadable down-counter; tick_c is high while the count sits at zero.
module uart_baud_timer #(
    parameter int unsigned W = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick_c
);
    logic [W-1:0] count_q;

    // Count down to zero and hold; a load always wins
    always_ff @(posedge clk) begin
        if (!rst_n)                count_q <= '0;
        else if (load)             count_q <= load_val;
        else if (count_q != '0)    count_q <= count_q - W'(1);
    end

    assign tick_c = (count_q == '0);
endmodule

// File: rtl/uart_tx_cfg.sv
// AXI4-Stream to UART serialiser with run-time frame format.
// Build option: UART_TX_BREAK_EN adds the break_req input and break/mark-after-break.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_cfg_if.slave          s_axis,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [3:0]            data_bits,
    input  logic [2:0]            parity_mode,
    input  logic                  stop_bits,
`ifdef UART_TX_BREAK_EN
    input  logic                  break_req,
`endif
    output logic                  txd,
    output logic                  busy
);
    localparam int unsigned TMR_W = PRESCALE_W + OVERSAMPLE_SHIFT;

    state_t                state_q, state_nxt;
    frame_cfg_t            cfg_q, cfg_nxt;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_nxt;
    logic [TMR_W-1:0]      ps_load_q, ps_load_nxt;
    logic [3:0]            bit_cnt_q, bit_cnt_nxt;
    logic                  par_q, par_nxt;
    logic                  stop_cnt_q, stop_cnt_nxt;
    logic                  txd_q, txd_nxt;
    logic                  tready_q, tready_nxt;
    logic                  busy_q, busy_nxt;

    logic                  tmr_load_c;
    logic [TMR_W-1:0]      tmr_val_c;
    logic                  tick_c;
    logic [PRESCALE_W-1:0] ps_eff_c;
    logic [TMR_W-1:0]      ps_in_load_c;
    logic [3:0]            nbits_in_c;
    logic                  par_bit_c;

    // Timer reload value from the live prescale input (0 acts as 1)
    assign ps_eff_c     = (prescale == '0) ? PRESCALE_W'(1) : prescale;
    assign ps_in_load_c = (TMR_W'(ps_eff_c) << OVERSAMPLE_SHIFT) - TMR_W'(1);

    // Clamp requested data bits into the supported range
    always_comb begin
        nbits_in_c = data_bits;
        if (data_bits < 4'(MIN_DATA_BITS))   nbits_in_c = 4'(MIN_DATA_BITS);
        else if (data_bits > 4'(DATA_WIDTH)) nbits_in_c = 4'(DATA_WIDTH);
    end

    // Parity bit for the latched mode and accumulated data
    always_comb begin
        case (cfg_q.pmode)
            PAR_EVEN: par_bit_c = par_q;
            PAR_ODD:  par_bit_c = ~par_q;
            PAR_MARK: par_bit_c = 1'b1;
            default:  par_bit_c = 1'b0;
        endcase
    end

    uart_baud_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .tick_c   (tick_c)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            shreg_q    <= '0;
            ps_load_q  <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            tready_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cfg_q      <= cfg_nxt;
            shreg_q    <= shreg_nxt;
            ps_load_q  <= ps_load_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            par_q      <= par_nxt;
            stop_cnt_q <= stop_cnt_nxt;
            txd_q      <= txd_nxt;
            tready_q   <= tready_nxt;
            busy_q     <= busy_nxt;
        end
    end

    // Next-state and next-output logic; bits advance on timer tick
    always_comb begin
        state_nxt    = state_q;
        cfg_nxt      = cfg_q;
        shreg_nxt    = shreg_q;
        ps_load_nxt  = ps_load_q;
        bit_cnt_nxt  = bit_cnt_q;
        par_nxt      = par_q;
        stop_cnt_nxt = stop_cnt_q;
        txd_nxt      = txd_q;
        tready_nxt   = tready_q;
        busy_nxt     = busy_q;
        tmr_load_c   = 1'b0;
        tmr_val_c    = ps_load_q;

        case (state_q)
            IDLE: begin
                txd_nxt    = 1'b1;
                tready_nxt = 1'b1;
                busy_nxt   = 1'b0;
                if (s_axis.tvalid && tready_q) begin
                    cfg_nxt.nbits = nbits_in_c;
                    cfg_nxt.pmode = norm_parity(parity_mode);
                    cfg_nxt.stop2 = stop_bits;
                    shreg_nxt     = s_axis.tdata;
                    ps_load_nxt   = ps_in_load_c;
                    bit_cnt_nxt   = '0;
                    par_nxt       = 1'b0;
                    stop_cnt_nxt  = 1'b0;
                    tmr_load_c    = 1'b1;
                    tmr_val_c     = ps_in_load_c;
                    state_nxt     = START;
                    txd_nxt       = 1'b0;
                    tready_nxt    = 1'b0;
                    busy_nxt      = 1'b1;
                end
`ifdef UART_TX_BREAK_EN
                else if (break_req) begin
                    state_nxt  = BREAK;
                    txd_nxt    = 1'b0;
                    tready_nxt = 1'b0;
                    busy_nxt   = 1'b1;
                end
`endif
            end
            START, DATA: begin
                if (tick_c) begin
                    tmr_load_c = 1'b1;
                    if (state_q == DATA && bit_cnt_q == cfg_q.nbits) begin
                        if (cfg_q.pmode == PAR_NONE) begin
                            state_nxt = STOP;
                            txd_nxt   = 1'b1;
                        end else begin
                            state_nxt = PARITY;
                            txd_nxt   = par_bit_c;
                        end
                    end else begin
                        state_nxt   = DATA;
                        txd_nxt     = shreg_q[0];
                        par_nxt     = par_q ^ shreg_q[0];
                        shreg_nxt   = shreg_q >> 1;
                        bit_cnt_nxt = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick_c) begin
                    tmr_load_c = 1'b1;
                    state_nxt  = STOP;
                    txd_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (tick_c) begin
                    if (cfg_q.stop2 && !stop_cnt_q) begin
                        tmr_load_c   = 1'b1;
                        stop_cnt_nxt = 1'b1;
                    end
`ifdef UART_TX_BREAK_EN
                    else if (break_req) begin
                        state_nxt = BREAK;
                        txd_nxt   = 1'b0;
                    end
`endif
                    else begin
                        state_nxt  = IDLE;
                        tready_nxt = 1'b1;
                        busy_nxt   = 1'b0;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                txd_nxt = 1'b0;
                if (!break_req) begin
                    state_nxt   = MAB;
                    txd_nxt     = 1'b1;
                    ps_load_nxt = ps_in_load_c;
                    tmr_load_c  = 1'b1;
                    tmr_val_c   = ps_in_load_c;
                end
            end
            MAB: begin
                if (tick_c) begin
                    state_nxt  = IDLE;
                    tready_nxt = 1'b1;
                    busy_nxt   = 1'b0;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign s_axis.tready = tready_q;
    assign txd           = txd_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected line bits queued at send time, checked by a line monitor.
module tb_uart_tx_cfg;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] prescale;
    logic [3:0]    data_bits;
    logic [2:0]    parity_mode;
    logic          stop_bits;
    logic          txd;
    logic          busy;
`ifdef UART_TX_BREAK_EN
    logic          break_req = 1'b0;
`endif

    uart_tx_cfg_if #(.DATA_WIDTH(DW)) axis ();

    uart_tx_cfg #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axis      (axis.slave),
        .prescale    (prescale),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
`ifdef UART_TX_BREAK_EN
        .break_req   (break_req),
`endif
        .txd         (txd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          period;
        bit          b2b;
    } frame_t;

    frame_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_sent   = 0;
    int mon_done = 0;
    int last_end = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Reference frame: start, clamped data LSB first, optional parity, stop bits
    function automatic frame_t mk(input logic [7:0] d, input int ps, input int nb,
                                  input int pm, input int sb, input bit b2b);
        frame_t f;
        int nbe;
        int k;
        logic p;
        nbe = (nb < 5) ? 5 : ((nb > 8) ? 8 : nb);
        f.bits = '0;
        k = 0;
        p = 1'b0;
        f.bits[k] = 1'b0; k++;
        for (int i = 0; i < nbe; i++) begin
            f.bits[k] = d[i];
            p = p ^ d[i];
            k++;
        end
        case (pm)
            1: begin f.bits[k] = p;    k++; end
            2: begin f.bits[k] = ~p;   k++; end
            3: begin f.bits[k] = 1'b1; k++; end
            4: begin f.bits[k] = 1'b0; k++; end
            default: ;
        endcase
        for (int i = 0; i <= sb; i++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.nbits  = k;
        f.period = ((ps == 0) ? 1 : ps) * 8;
        f.b2b    = b2b;
        return f;
    endfunction

    task automatic send(input logic [7:0] d, input int ps, input int nb,
                        input int pm, input int sb, input bit b2b);
        int n;
        exp_q.push_back(mk(d, ps, nb, pm, sb, b2b));
        n_sent++;
        @(negedge clk);
        axis.tdata  = d;
        prescale    = PW'(ps);
        data_bits   = 4'(nb);
        parity_mode = 3'(pm);
        stop_bits   = 1'(sb);
        axis.tvalid = 1'b1;
        n = 0;
        while (axis.tready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("handshake", axis.tready, 1);
        @(posedge clk);
        #1 axis.tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (mon_done < n_sent && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("frames_done", mon_done, n_sent);
    endtask

    // Line monitor: checks each bit value, its length, and tready/busy around the frame
    initial begin
        frame_t f;
        int n;
        bit shape_ok;
        logic obs;
        forever begin
            wait (exp_q.size() != 0);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (txd !== 1'b0 && n < 3000);
            f = exp_q.pop_front();
            check_eq("start_seen", txd, 0);
            if (txd === 1'b0) begin
                if (f.b2b) check_eq("b2b_gap", cyc - last_end, 1);
                shape_ok = 1'b1;
                for (int i = 0; i < f.nbits; i++) begin
                    obs = 1'bx;
                    for (int c = 0; c < f.period; c++) begin
                        if (!(i == 0 && c == 0)) @(negedge clk);
                        if (c == f.period / 2) obs = txd;
                        if (txd !== f.bits[i] || axis.tready !== 1'b0 || busy !== 1'b1)
                            shape_ok = 1'b0;
                    end
                    check_eq($sformatf("bit%0d", i), obs, f.bits[i]);
                end
                check_eq("frame_shape", shape_ok, 1);
                @(negedge clk);
                check_eq("end_txd", txd, 1);
                check_eq("end_tready", axis.tready, 1);
                check_eq("end_busy", busy, 0);
                last_end = cyc;
            end
            mon_done++;
        end
    end

    initial begin
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        prescale    = PW'(1);
        data_bits   = 4'd8;
        parity_mode = 3'd0;
        stop_bits   = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_txd", txd, 1);
        check_eq("rst_tready", axis.tready, 0);
        check_eq("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_tready", axis.tready, 1);

        // Unscored frame aborted by reset during data bit 3
        axis.tdata  = 8'h00;
        axis.tvalid = 1'b1;
        @(posedge clk);
        #1 axis.tvalid = 1'b0;
        repeat (35) @(negedge clk);
        check_eq("abort_pre_txd", txd, 0);
        check_eq("abort_pre_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_txd", txd, 1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_tready", axis.tready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("abort_rel_tready", axis.tready, 1);
        check_eq("abort_rel_busy", busy, 0);

        send(8'h55, 1, 8, 0, 0, 1'b0); wait_idle();
        send(8'h41, 2, 7, 1, 1, 1'b0); wait_idle();
        send(8'hFF, 1, 5, 2, 0, 1'b0); wait_idle();
        send(8'hFF, 1, 5, 3, 0, 1'b0); wait_idle();
        send(8'hFF, 1, 5, 4, 0, 1'b0); wait_idle();

        // Back-to-back with config changed while the previous frame is on the line
        send(8'hA5, 1, 8, 0, 0, 1'b0);
        send(8'h3C, 0, 8, 1, 0, 1'b1);
        send(8'h96, 3, 6, 2, 1, 1'b1);
        wait_idle();

        // Clamping and undefined parity encodings
        send(8'hE6, 2, 2, 6, 0, 1'b0); wait_idle();
        send(8'hC3, 1, 15, 1, 1, 1'b0); wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
AXI4-Stream to UART serialiser with run-time frame format: 5–DATA_WIDTH data bits, optional parity (none/even/odd/mark/space) and 1 or 2 stop bits. It replaces the fixed 8N1 transmitter in the UART subsystem. A single word is accepted per frame. The bit period is prescale×8 clocks, so it shares the prescale value with the 8× oversampling receiver.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame and the width of s_axis_tdata (5..9).
PRESCALE_W, 16, width of the prescale input.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous reset, active-low
s_axis_tdata  input  DATA_WIDTH  word to send; LSB is sent first
s_axis_tvalid  input  1  source has a word
s_axis_tready  output  1  block accepts a word this cycle
txd  output  1  serial line; idles high
busy  output  1  frame in progress
prescale  input  PRESCALE_W  bit period = prescale×8 clocks; 0 is treated as 1
data_bits  input  4  data bits per frame, 5..DATA_WIDTH; out-of-range values clamp to the nearest limit
parity_mode  input  3  0 none, 1 even, 2 odd, 3 mark (1), 4 space (0); 5–7 behave as none
stop_bits  input  1  0 → one stop bit, 1 → two stop bits

Behaviour:
- Reset (rst_n low at a clock edge): txd=1, s_axis_tready=0, busy=0, state IDLE, counters 0. Reset mid-frame aborts the frame; txd is 1 on the following cycle.
- The clock and reset scheme is decided: one clock, and reset is synchronous and active-low.
- All outputs are registered.
- States: IDLE → START → DATA → PARITY → STOP → IDLE. PARITY is skipped when parity_mode is none.
- IDLE: s_axis_tready=1 from the first cycle after reset release. A transfer occurs when tvalid&&tready.
- On a transfer, in the same cycle:
  - latch tdata, prescale, data_bits, parity_mode and stop_bits into shadow registers;
  - tready goes to 0 and busy to 1 on the next edge.
- Input changes mid-frame have no effect.
- START: txd=0 for one bit period, starting the cycle after acceptance.
- DATA: latched bits [0..data_bits-1], LSB first, one bit period each. Unused upper tdata bits are ignored.
- PARITY, one bit period:
  - even: XOR of the sent bits;
  - odd: its inverse;
  - mark: 1;
  - space: 0.
- STOP: txd=1 for 1 or 2 bit periods.
- After the last stop-bit period the block returns to IDLE: busy=0 and tready=1 in the same cycle.
- Back-to-back frames: with tvalid held high, the next start bit begins exactly one clock after the previous stop bit ends. The line is therefore high for stop-period+1 clocks between frames.
- Bit timer: a PRESCALE_W+3 bit down-counter, loaded with (prescale×8)-1. The bit advances when it reaches 0. There is no wrap: the maximum prescale gives a 2^(PRESCALE_W+3)-8 cycle period.
- Frame length in clocks: (1+data_bits+parity?1:0+stop_bits+1)×prescale×8.
- tvalid deasserting without a transfer has no effect.
- tdata is sampled only on the handshake cycle.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - adds input break_req (1 bit);
  - while break_req=1 and state is IDLE, txd=0, tready=0 and busy=1;
  - a request raised mid-frame waits until the frame completes;
  - on release, txd=1 for one full bit period (mark-after-break) before IDLE reasserts tready.
- Undefined: no break_req port, and the logic is absent.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, plus BREAK and MAB under the macro);
  - parity_mode encodings (PAR_NONE..PAR_SPACE);
  - the localparams MIN_DATA_BITS=5 and OVERSAMPLE_SHIFT=3.
- One sub-module, uart_baud_timer: loadable down-counter with a tick output, reusable by the receiver.

Test Plan:
- prescale=1, 8N1, tdata=0x55 → txd 0,1,0,1,0,1,0,1,0,1, each held 8 clocks (80 clocks total); tready low 80 clocks.
- prescale=2, data_bits=7, even parity, 2 stop, tdata=0x41 → start, 1000001, parity 0, stop 1,1; each bit 16 clocks, 176 clocks total.
- Odd parity, data_bits=5, tdata=0xFF → data 11111, parity 0; mark/space modes give parity 1/0 for the same data.
- tvalid held high with 3 words → frames separated by exactly one idle-high clock; busy drops for exactly one cycle between frames.
- rst_n low in DATA state bit 3 → the next cycle txd=1, busy=0, tready=0; tready=1 one cycle after rst_n rises.
- prescale=0 → 8-clock bits; changing prescale/parity_mode mid-frame leaves the current frame unchanged and the next frame uses the new values.
